// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU program sequencer.
// Instruction layout: op[18:16], a[15:8], b[7:0].
package alu_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int OP_W    = 3;
    localparam int INSTR_W = OP_W + 2 * DATA_W;
    localparam int CNT_W   = ADDR_W + 1;

    typedef enum logic [OP_W-1:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        SHL = 3'd2,
        SHR = 3'd3,
        AND = 3'd4,
        OR  = 3'd5,
        XOR = 3'd6,
        NOT = 3'd7
    } op_t;

    typedef struct packed {
        op_t               op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu_program_sequencer_seq_pc.sv
// Wrapping program counter for the sequencer.
// Holds the run's final address and flags when pc reaches it.
module seq_pc
    import alu_pkg::*;
(
    input  logic              clk1,
    input  logic              reset1,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              at_last
);

    logic [ADDR_W-1:0] lastr;

    // Load the run window on start, else step modulo 64.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            pc    <= '0;
            lastr <= '0;
        end else if (load) begin
            pc    <= load_addr;
            lastr <= last_addr;
        end else if (inc) begin
            pc    <= pc + 1'b1;
        end
    end

    assign at_last = (pc == lastr);

endmodule

// File: rtl/alu_program_sequencer.sv
// Fetch/execute/write sequencer driving the ROM and 8-bit ALU.
// Results leave through a valid/ready handshake.
module alu_program_sequencer
    import alu_pkg::*;
(
    input  logic               clk1,
    input  logic               reset1,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  last_addr,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  res_data,
    output logic [ADDR_W-1:0]  res_addr,
    output logic               res_zero,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   instr_cnt
);

    seq_state_t        state;
    seq_state_t        nxt;
    instr_t            ir;
    logic [ADDR_W-1:0] pc;
    logic              at_last;
    logic              ld;
    logic              fire;
    logic              inc;

    assign ld   = (state == S_IDLE) && start && !abort;
    assign fire = (state == S_WRITE) && res_ready && !abort;
    assign inc  = fire && !at_last;

    seq_pc u_pc (
        .clk1      (clk1),
        .reset1    (reset1),
        .load      (ld),
        .inc       (inc),
        .load_addr (start_addr),
        .last_addr (last_addr),
        .pc        (pc),
        .at_last   (at_last)
    );

    // State register.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next state; abort overrides every other input.
    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            unique case (1'b1)
                (state == S_IDLE):  if (start) nxt = S_FETCH;
                (state == S_FETCH): nxt = S_EXEC;
                (state == S_EXEC):  nxt = S_WRITE;
                (state == S_WRITE):
                    if (res_ready)
                        nxt = at_last ? S_DONE : S_FETCH;
                (state == S_DONE):  nxt = S_IDLE;
                default:            nxt = S_IDLE;
            endcase
        end
    end

    // Instruction latch, result capture and run counter.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            ir        <= '0;
            res_data  <= '0;
            res_addr  <= '0;
            instr_cnt <= '0;
        end else begin
            if (ld)
                instr_cnt <= '0;
            if (fire)
                instr_cnt <= instr_cnt + 1'b1;
            if ((state == S_FETCH) && !abort)
                ir <= instr_t'(rom_data);
            if ((state == S_EXEC) && !abort) begin
                res_data <= alu_result;
                res_addr <= pc;
            end
        end
    end

    assign rom_addr  = pc;
    assign alu_op    = ir.op;
    assign alu_a     = ir.a;
    assign alu_b     = ir.b;
    assign res_zero  = (res_data == '0);
    assign res_valid = (state == S_WRITE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Bench for alu_program_sequencer: ROM and ALU models,
// expected result stream derived from the run window.
module tb_alu_program_sequencer;

    logic        clk1 = 1'b0;
    logic        reset1;
    logic        start;
    logic        abort;
    logic [5:0]  start_addr;
    logic [5:0]  last_addr;
    logic [5:0]  rom_addr;
    logic [18:0] rom_data;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic [7:0]  res_data;
    logic [5:0]  res_addr;
    logic        res_zero;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic [6:0]  instr_cnt;

    logic [18:0] rom [64];
    logic [7:0]  got_d [$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk1 = ~clk1;

    alu_program_sequencer dut (
        .clk1       (clk1),
        .reset1     (reset1),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .last_addr  (last_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .res_data   (res_data),
        .res_addr   (res_addr),
        .res_zero   (res_zero),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .done       (done),
        .instr_cnt  (instr_cnt)
    );

    function automatic logic [7:0] alu_ref(input logic [18:0] w);
        logic [7:0] a;
        logic [7:0] b;
        a = w[15:8];
        b = w[7:0];
        case (w[18:16])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << b;
            3'd3:    return a >> b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign rom_data   = rom[rom_addr];
    assign alu_result = alu_ref({alu_op, alu_a, alu_b});

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // One program run from s to l; the expected stream is the
    // address list s, s+1, ... l (mod 64) and the ALU of each word.
    task automatic run(input int s, input int l,
                       input int pstall, input bit poke);
        logic [5:0] ea [$];
        logic [7:0] hd;
        logic [5:0] ha;
        int a;
        int n;
        int cyc;
        int lastc;
        bit stalled;
        bit fin;
        a = s;
        n = 0;
        cyc = 0;
        lastc = 0;
        stalled = 0;
        fin = 0;
        hd = '0;
        ha = '0;
        got_d.delete();
        for (int k = 0; k < 64; k++) begin
            ea.push_back(6'(a));
            if (a == l) break;
            a = (a + 1) % 64;
        end
        @(negedge clk1);
        start = 1;
        start_addr = 6'(s);
        last_addr = 6'(l);
        res_ready = 0;
        while (!fin && cyc < 4000) begin
            @(negedge clk1);
            cyc++;
            start = 0;
            if (res_valid) begin
                chk("pc_hold", 32'(rom_addr), 32'(res_addr));
                if (stalled) begin
                    chk("stable_data", 32'(res_data), 32'(hd));
                    chk("stable_addr", 32'(res_addr), 32'(ha));
                    if (poke) begin
                        start = 1;
                        start_addr = 6'($urandom);
                        last_addr = 6'($urandom);
                    end
                end
                res_ready = ($urandom_range(0, 99) >= pstall);
                if (res_ready) begin
                    if (n < ea.size()) begin
                        chk("res_addr", 32'(res_addr), 32'(ea[n]));
                        chk("res_data", 32'(res_data),
                            32'(alu_ref(rom[ea[n]])));
                        chk("res_zero", 32'(res_zero),
                            32'(alu_ref(rom[ea[n]]) == 8'h00));
                    end else begin
                        chk("extra_result", n, ea.size());
                    end
                    if (pstall == 0)
                        chk("spacing", cyc - lastc, 3);
                    lastc = cyc;
                    got_d.push_back(res_data);
                    n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hd = res_data;
                    ha = res_addr;
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
            if (done) begin
                fin = 1;
                chk("done_after", cyc - lastc, 1);
                chk("res_count", n, ea.size());
                chk("instr_cnt", 32'(instr_cnt), ea.size());
                chk("valid_in_done", 32'(res_valid), 0);
                if (poke) begin
                    start = 1;
                    start_addr = 6'($urandom);
                end
            end
        end
        chk("run_timeout", 32'(fin), 1);
        @(negedge clk1);
        start = 0;
        res_ready = 0;
        chk("done_pulse", 32'(done), 0);
        chk("idle_after", 32'(busy), 0);
    endtask

    initial begin
        int dn;
        reset1 = 1;
        start = 0;
        abort = 0;
        res_ready = 0;
        start_addr = '0;
        last_addr = '0;
        for (int i = 0; i < 64; i++)
            rom[i] = 19'($urandom);
        rom[0] = 19'b000_00010111_00010011;
        rom[1] = 19'b001_00000111_01001100;
        rom[2] = 19'b010_00011111_00000101;
        rom[3] = {3'd6, 8'h55, 8'h55};

        @(negedge clk1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_data", 32'(res_data), 0);
        reset1 = 0;

        run(0, 0, 0, 0);
        chk("t1_value", 32'(got_d[0]), 32'h2A);
        run(1, 2, 0, 0);
        chk("t2_first", 32'(got_d[0]), 32'hBB);
        chk("t2_second", 32'(got_d[1]), 32'hE0);
        run(0, 3, 70, 1);
        run(62, 1, 0, 0);
        run(62, 1, 40, 1);
        run(1, 0, 20, 0);

        // Abort in EXEC of the second instruction.
        @(negedge clk1);
        start = 1;
        start_addr = 6'd0;
        last_addr = 6'd3;
        res_ready = 1;
        repeat (5) begin
            @(negedge clk1);
            start = 0;
        end
        chk("abort_exec_addr", 32'(rom_addr), 1);
        abort = 1;
        @(negedge clk1);
        abort = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_cnt", 32'(instr_cnt), 1);
        dn = 0;
        repeat (4) begin
            @(negedge clk1);
            dn += int'(done);
        end
        chk("abort_no_done", dn, 0);

        // Abort beats res_ready in WRITE and start in IDLE.
        start = 1;
        start_addr = 6'd5;
        last_addr = 6'd5;
        repeat (3) begin
            @(negedge clk1);
            start = 0;
        end
        chk("abort_wr_valid", 32'(res_valid), 1);
        abort = 1;
        @(negedge clk1);
        chk("abort_wr_cnt", 32'(instr_cnt), 0);
        chk("abort_wr_busy", 32'(busy), 0);
        start = 1;
        @(negedge clk1);
        start = 0;
        abort = 0;
        chk("abort_start", 32'(busy), 0);

        // Asynchronous reset between edges during WRITE.
        res_ready = 0;
        start = 1;
        start_addr = 6'd2;
        last_addr = 6'd3;
        repeat (4) begin
            @(negedge clk1);
            start = 0;
        end
        chk("pre_rst_valid", 32'(res_valid), 1);
        #2 reset1 = 1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(res_valid), 0);
        chk("arst_rom_addr", 32'(rom_addr), 0);
        chk("arst_data", 32'(res_data), 0);
        chk("arst_addr", 32'(res_addr), 0);
        chk("arst_zero", 32'(res_zero), 1);
        chk("arst_cnt", 32'(instr_cnt), 0);
        chk("arst_alu", 32'({alu_op, alu_a, alu_b}), 0);
        @(negedge clk1);
        reset1 = 0;
        run(0, 3, 30, 0);

        for (int r = 0; r < 6; r++)
            run($urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 60),
                1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
